// File: rtl/bidir_direction_arbiter.sv
// Direction arbiter for a shared bidirectional buffer: one-edge grant when the buffer already faces the target,
// TURN_CYCLES dead cycles on a direction change, MAX_HOLD preemption; ARB_STATS_EN adds a turnaround counter.
module bidir_direction_arbiter #(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_HOLD    = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sender_req,
  input  logic             reciever_req,
  output logic             sender_gnt,
  output logic             reciever_gnt,
  output logic             sender_port,
  output logic             bus_en,
  output logic             turn_active
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] switch_count
`endif
);

  localparam int TURN_W = 4;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 15 || MAX_HOLD < 1 || CNT_W < 1) begin : g_param_err
    $error("bidir_direction_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_RECV = 2'd2,
    S_TURN = 2'd3
  } state_t;

  // Direction values: 1 = sender side, 0 = reciever side.
  state_t              r_state;
  logic                r_last_owner;
  logic                r_target;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [TURN_W-1:0]   r_turn_cnt;
  logic                r_sender_gnt;
  logic                r_reciever_gnt;
  logic                r_sender_port;
  logic                r_bus_en;
  logic                r_turn_active;

  state_t              w_state_nxt;
  logic                w_last_owner_nxt;
  logic                w_target_nxt;
  logic [HOLD_W-1:0]   w_hold_cnt_nxt;
  logic [TURN_W-1:0]   w_turn_cnt_nxt;
  logic                w_sender_gnt_nxt;
  logic                w_reciever_gnt_nxt;
  logic                w_sender_port_nxt;
  logic                w_bus_en_nxt;
  logic                w_turn_active_nxt;

  logic                w_pick;
  logic                w_own;
  logic                w_own_req;
  logic                w_oth_req;
  logic                w_tgt_req;

  // With both sides asking from idle, the side that did not own the bus last goes first.
  assign w_pick    = (sender_req & reciever_req) ? ~r_last_owner : sender_req;
  assign w_own     = (r_state == S_SEND);
  assign w_own_req = w_own ? sender_req : reciever_req;
  assign w_oth_req = w_own ? reciever_req : sender_req;
  assign w_tgt_req = r_target ? sender_req : reciever_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_last_owner   <= 1'b0;
      r_target       <= 1'b0;
      r_hold_cnt     <= '0;
      r_turn_cnt     <= '0;
      r_sender_gnt   <= 1'b0;
      r_reciever_gnt <= 1'b0;
      r_sender_port  <= 1'b0;
      r_bus_en       <= 1'b0;
      r_turn_active  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_last_owner   <= w_last_owner_nxt;
      r_target       <= w_target_nxt;
      r_hold_cnt     <= w_hold_cnt_nxt;
      r_turn_cnt     <= w_turn_cnt_nxt;
      r_sender_gnt   <= w_sender_gnt_nxt;
      r_reciever_gnt <= w_reciever_gnt_nxt;
      r_sender_port  <= w_sender_port_nxt;
      r_bus_en       <= w_bus_en_nxt;
      r_turn_active  <= w_turn_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_last_owner_nxt   = r_last_owner;
    w_target_nxt       = r_target;
    w_hold_cnt_nxt     = r_hold_cnt;
    w_turn_cnt_nxt     = r_turn_cnt;
    w_sender_gnt_nxt   = 1'b0;
    w_reciever_gnt_nxt = 1'b0;
    w_sender_port_nxt  = r_sender_port;
    w_bus_en_nxt       = 1'b0;
    w_turn_active_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (sender_req || reciever_req) begin
          if (w_pick == r_sender_port) begin
            w_state_nxt        = w_pick ? S_SEND : S_RECV;
            w_sender_gnt_nxt   = w_pick;
            w_reciever_gnt_nxt = ~w_pick;
            w_bus_en_nxt       = 1'b1;
            w_hold_cnt_nxt     = '0;
          end else begin
            w_state_nxt       = S_TURN;
            w_target_nxt      = w_pick;
            w_sender_port_nxt = w_pick;
            w_turn_active_nxt = 1'b1;
            w_turn_cnt_nxt    = '0;
          end
        end
      end

      S_TURN: begin
        if (r_turn_cnt == TURN_LAST) begin
          if (w_tgt_req) begin
            w_state_nxt        = r_target ? S_SEND : S_RECV;
            w_sender_gnt_nxt   = r_target;
            w_reciever_gnt_nxt = ~r_target;
            w_bus_en_nxt       = 1'b1;
            w_hold_cnt_nxt     = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_turn_cnt_nxt    = r_turn_cnt + 1'b1;
          w_turn_active_nxt = 1'b1;
        end
      end

      S_SEND, S_RECV: begin
        // ">=" so a request arriving after the counter saturated still preempts at once.
        if (!w_own_req || (w_oth_req && (r_hold_cnt >= HOLD_LAST))) begin
          w_last_owner_nxt = w_own;
          if (w_oth_req) begin
            w_state_nxt       = S_TURN;
            w_target_nxt      = ~w_own;
            w_sender_port_nxt = ~w_own;
            w_turn_active_nxt = 1'b1;
            w_turn_cnt_nxt    = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_sender_gnt_nxt   = w_own;
          w_reciever_gnt_nxt = ~w_own;
          w_bus_en_nxt       = 1'b1;
          if (r_hold_cnt != HOLD_SAT) begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign sender_gnt   = r_sender_gnt;
  assign reciever_gnt = r_reciever_gnt;
  assign sender_port  = r_sender_port;
  assign bus_en       = r_bus_en;
  assign turn_active  = r_turn_active;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] r_switch_count;
  logic             w_turn_done;

  assign w_turn_done = (r_state == S_TURN) && (r_turn_cnt == TURN_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_switch_count <= '0;
    end else if (w_turn_done && (r_switch_count != {CNT_W{1'b1}})) begin
      r_switch_count <= r_switch_count + 1'b1;
    end
  end

  assign switch_count = r_switch_count;
`endif

  a_one_hot_gnt : assert property (@(posedge clk) disable iff (!rst_n)
    !(sender_gnt && reciever_gnt));
  a_sender_gnt_dir : assert property (@(posedge clk) disable iff (!rst_n)
    sender_gnt |-> (sender_port && bus_en));
  a_reciever_gnt_dir : assert property (@(posedge clk) disable iff (!rst_n)
    reciever_gnt |-> (!sender_port && bus_en));
  a_turn_bus_off : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_TURN) |-> !bus_en);

endmodule

// File: tb/tb_bidir_direction_arbiter.sv
// Bench for bidir_direction_arbiter: directed vector table, hand sequences and randomized traffic vs a reference model.
module tb_bidir_direction_arbiter;
  localparam int TC = 2;
  localparam int MH = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sender_req = 1'b0;
  logic reciever_req = 1'b0;
  logic sender_gnt, reciever_gnt, sender_port, bus_en, turn_active;
`ifdef ARB_STATS_EN
  logic [CW-1:0] switch_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bidir_direction_arbiter #(.TURN_CYCLES(TC), .MAX_HOLD(MH), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sender_req(sender_req),
    .reciever_req(reciever_req),
    .sender_gnt(sender_gnt),
    .reciever_gnt(reciever_gnt),
    .sender_port(sender_port),
    .bus_en(bus_en),
    .turn_active(turn_active)
`ifdef ARB_STATS_EN
    ,
    .switch_count(switch_count)
`endif
  );

  // Reference model: owner -1 = nobody, 0 = reciever, 1 = sender.
  int m_owner = -1;
  int m_last = 0;
  int m_port = 0;
  int m_turn_left = 0;
  int m_tgt = 0;
  int m_served = 0;
  int m_switches = 0;

  logic prev_en = 1'b0;
  logic prev_port = 1'b0;

  task automatic model_begin_turn(input int dir);
    m_port = dir;
    m_tgt = dir;
    m_turn_left = TC;
  endtask

  task automatic model_step(input logic rst, input logic s, input logic r);
    int req[2];
    int other;
    int tgt;
    req[0] = int'(r);
    req[1] = int'(s);
    if (!rst) begin
      m_owner = -1; m_last = 0; m_port = 0; m_turn_left = 0;
      m_tgt = 0; m_served = 0; m_switches = 0;
    end else if (m_turn_left > 0) begin
      m_turn_left--;
      if (m_turn_left == 0) begin
        if (m_switches < (1 << CW) - 1) m_switches++;
        if (req[m_tgt] != 0) begin
          m_owner = m_tgt;
          m_served = 1;
        end
      end
    end else if (m_owner >= 0) begin
      other = 1 - m_owner;
      if (req[m_owner] == 0 || (req[other] != 0 && m_served >= MH)) begin
        m_last = m_owner;
        m_owner = -1;
        if (req[other] != 0) model_begin_turn(other);
      end else begin
        m_served++;
      end
    end else if (s || r) begin
      tgt = (s && r) ? 1 - m_last : (s ? 1 : 0);
      if (tgt == m_port) begin
        m_owner = tgt;
        m_served = 1;
      end else begin
        model_begin_turn(tgt);
      end
    end
  endtask

  task automatic check_model();
    logic [4:0] act;
    logic [4:0] exp;
    act = {sender_gnt, reciever_gnt, sender_port, bus_en, turn_active};
    exp = {m_owner == 1, m_owner == 0, m_port[0], m_owner >= 0, m_turn_left > 0};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model t=%0t {sgnt,rgnt,port,en,turn} got %b, expected %b", $time, act, exp);
    end
    n_cmp++;
    if ((sender_gnt && reciever_gnt) || (sender_gnt && !(sender_port && bus_en)) ||
        (reciever_gnt && !(!sender_port && bus_en)) || (turn_active && bus_en) ||
        (prev_en && bus_en && (prev_port != sender_port))) begin
      n_bad++;
      $display("FAIL invariant t=%0t got %b prev_en=%b prev_port=%b, expected a legal combination",
               $time, act, prev_en, prev_port);
    end
`ifdef ARB_STATS_EN
    n_cmp++;
    if (int'(switch_count) != m_switches) begin
      n_bad++;
      $display("FAIL switch_count model t=%0t got %0d, expected %0d", $time, switch_count, m_switches);
    end
`endif
    prev_en = bus_en;
    prev_port = sender_port;
  endtask

  task automatic step(input logic rst, input logic s, input logic r);
    rst_n = rst;
    sender_req = s;
    reciever_req = r;
    @(posedge clk);
    model_step(rst, s, r);
    #1;
    check_model();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       s;
    logic       r;
    logic [4:0] exp;   // {sender_gnt, reciever_gnt, sender_port, bus_en, turn_active}
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic rst, input logic s, input logic r, input logic [4:0] exp);
    vec_t v;
    v.rst = rst; v.s = s; v.r = r; v.exp = exp;
    return v;
  endfunction

  initial begin
    int cnt;
    int tcnt;
    logic s_n;
    logic r_n;
    logic rst_v;

    tbl[0]  = mk(0, 0, 0, 5'b00000);
    tbl[1]  = mk(1, 0, 0, 5'b00000);
    tbl[2]  = mk(1, 1, 0, 5'b00101);  // turnaround toward sender begins
    tbl[3]  = mk(1, 1, 0, 5'b00101);
    tbl[4]  = mk(1, 1, 0, 5'b10110);  // grant after N+2
    tbl[5]  = mk(1, 0, 0, 5'b00100);
    tbl[6]  = mk(1, 1, 0, 5'b10110);  // already facing sender: one edge
    tbl[7]  = mk(1, 0, 0, 5'b00100);
    tbl[8]  = mk(1, 0, 1, 5'b00001);
    tbl[9]  = mk(1, 0, 1, 5'b00001);
    tbl[10] = mk(1, 0, 1, 5'b01010);
    tbl[11] = mk(1, 0, 0, 5'b00000);
    tbl[12] = mk(1, 1, 0, 5'b00101);
    tbl[13] = mk(1, 1, 0, 5'b00101);  // turn_cnt now 1
    tbl[14] = mk(0, 1, 0, 5'b00000);  // reset mid-turnaround
    tbl[15] = mk(1, 0, 1, 5'b01010);  // reciever granted without turnaround
    tbl[16] = mk(1, 0, 0, 5'b00000);
    tbl[17] = mk(0, 0, 0, 5'b00000);
    tbl[18] = mk(1, 0, 1, 5'b01010);
    tbl[19] = mk(1, 0, 0, 5'b00000);
    tbl[20] = mk(1, 1, 0, 5'b00101);
    tbl[21] = mk(1, 0, 0, 5'b00101);  // dropped request does not abort the turn
    tbl[22] = mk(1, 0, 0, 5'b00100);  // turn ends in idle facing sender
    tbl[23] = mk(1, 1, 0, 5'b10110);
    tbl[24] = mk(1, 0, 0, 5'b00100);

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].rst, tbl[i].s, tbl[i].r);
      n_cmp++;
      if ({sender_gnt, reciever_gnt, sender_port, bus_en, turn_active} !== tbl[i].exp) begin
        n_bad++;
        $display("FAIL vec %0d: got %b, expected %b", i,
                 {sender_gnt, reciever_gnt, sender_port, bus_en, turn_active}, tbl[i].exp);
      end
    end

    // Both sides at once from reset: sender first, reciever two cycles after sender lets go.
    step(0, 0, 0);
    step(1, 1, 1); chk("t3 turn start", int'(turn_active), 1);
    step(1, 1, 1);
    step(1, 1, 1); chk("t3 sender granted", int'(sender_gnt), 1);
    step(1, 1, 1); chk("t3 sender held", int'(sender_gnt), 1);
    step(1, 0, 1); chk("t3 sender released", int'(sender_gnt), 0);
    chk("t3 turn toward reciever", int'(turn_active), 1);
    step(1, 0, 1); chk("t3 reciever not yet", int'(reciever_gnt), 0);
    step(1, 0, 1); chk("t3 reciever granted", int'(reciever_gnt), 1);

    // Preemption after MH grant cycles, then TC dead cycles.
    step(0, 0, 0);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    chk("t4 sender granted", int'(sender_gnt), 1);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 1);
      if (sender_gnt) cnt++;
      else break;
    end
    chk("t4 grant cycles before preempt", cnt, MH);
    tcnt = turn_active ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 1);
      if (reciever_gnt) break;
      if (turn_active) tcnt++;
    end
    chk("t4 turnaround cycles", tcnt, TC);
    chk("t4 reciever granted", int'(reciever_gnt), 1);

    // Uncontested owner keeps the bus indefinitely.
    step(0, 0, 0);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step(1, 1, 0);
      if (sender_gnt) cnt++;
    end
    chk("t4 long hold", cnt, 25);

`ifdef ARB_STATS_EN
    step(0, 0, 0);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    chk("t6 final owner sender", int'(sender_gnt), 1);
    chk("t6 switch_count", int'(switch_count), 3);
`endif

    // Randomized traffic: requesters mostly hold until served, occasional reset.
    step(0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      if (sender_gnt) s_n = ($urandom % 4) != 0;
      else if (sender_req) s_n = ($urandom % 40) != 0;
      else s_n = ($urandom % 3) == 0;
      if (reciever_gnt) r_n = ($urandom % 4) != 0;
      else if (reciever_req) r_n = ($urandom % 40) != 0;
      else r_n = ($urandom % 3) == 0;
      rst_v = ($urandom % 150) != 0;
      step(rst_v, s_n, r_n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
